// File: rtl/add_imp_pkg.sv
// Shared widths, FSM state type and bound helper for the ADD_IMP frame sequencer.
package add_imp_pkg;

  localparam int OP_W    = 4;
  localparam int NUM_OPS = 128;
  localparam int SUM_W   = 11;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SETTLE,
    HOLD
  } state_t;

  // Largest total the tree can ever produce: every slot at its maximum nibble.
  function automatic logic [SUM_W-1:0] max_sum();
    return SUM_W'(NUM_OPS * (2 ** OP_W - 1));
  endfunction

endpackage

// File: rtl/add_imp_frame_ctrl_if.sv
// Operand stream in and sum stream out of the ADD_IMP frame sequencer.
interface add_imp_frame_ctrl_if;
  import add_imp_pkg::*;

  logic             in_valid;
  logic [OP_W-1:0]  in_data;
  logic             in_last;
  logic             in_ready;
  logic             sum_valid;
  logic [SUM_W-1:0] sum_data;
  logic             sum_ready;
  logic             short_frame;

  modport master (
    output in_valid, in_data, in_last, sum_ready,
    input  in_ready, sum_valid, sum_data, short_frame
  );

  modport slave (
    input  in_valid, in_data, in_last, sum_ready,
    output in_ready, sum_valid, sum_data, short_frame
  );

endinterface

// File: rtl/ADD_IMP.sv
// Combinational 128-operand, 4-bit adder tree producing an 11-bit total.
module ADD_IMP (
  input  logic [3:0]  a1,   a2,   a3,   a4,   a5,   a6,   a7,   a8,   a9,   a10,  a11,  a12,  a13,  a14,  a15,  a16,
  input  logic [3:0]  a17,  a18,  a19,  a20,  a21,  a22,  a23,  a24,  a25,  a26,  a27,  a28,  a29,  a30,  a31,  a32,
  input  logic [3:0]  a33,  a34,  a35,  a36,  a37,  a38,  a39,  a40,  a41,  a42,  a43,  a44,  a45,  a46,  a47,  a48,
  input  logic [3:0]  a49,  a50,  a51,  a52,  a53,  a54,  a55,  a56,  a57,  a58,  a59,  a60,  a61,  a62,  a63,  a64,
  input  logic [3:0]  a65,  a66,  a67,  a68,  a69,  a70,  a71,  a72,  a73,  a74,  a75,  a76,  a77,  a78,  a79,  a80,
  input  logic [3:0]  a81,  a82,  a83,  a84,  a85,  a86,  a87,  a88,  a89,  a90,  a91,  a92,  a93,  a94,  a95,  a96,
  input  logic [3:0]  a97,  a98,  a99,  a100, a101, a102, a103, a104, a105, a106, a107, a108, a109, a110, a111, a112,
  input  logic [3:0]  a113, a114, a115, a116, a117, a118, a119, a120, a121, a122, a123, a124, a125, a126, a127, a128,
  output logic [10:0] sum
);

  logic [3:0] ops [128];

  assign ops = '{a1,   a2,   a3,   a4,   a5,   a6,   a7,   a8,   a9,   a10,  a11,  a12,  a13,  a14,  a15,  a16,
                 a17,  a18,  a19,  a20,  a21,  a22,  a23,  a24,  a25,  a26,  a27,  a28,  a29,  a30,  a31,  a32,
                 a33,  a34,  a35,  a36,  a37,  a38,  a39,  a40,  a41,  a42,  a43,  a44,  a45,  a46,  a47,  a48,
                 a49,  a50,  a51,  a52,  a53,  a54,  a55,  a56,  a57,  a58,  a59,  a60,  a61,  a62,  a63,  a64,
                 a65,  a66,  a67,  a68,  a69,  a70,  a71,  a72,  a73,  a74,  a75,  a76,  a77,  a78,  a79,  a80,
                 a81,  a82,  a83,  a84,  a85,  a86,  a87,  a88,  a89,  a90,  a91,  a92,  a93,  a94,  a95,  a96,
                 a97,  a98,  a99,  a100, a101, a102, a103, a104, a105, a106, a107, a108, a109, a110, a111, a112,
                 a113, a114, a115, a116, a117, a118, a119, a120, a121, a122, a123, a124, a125, a126, a127, a128};

  always_comb begin
    sum = '0;
    for (int i = 0; i < 128; i++) sum = sum + 11'(ops[i]);
  end

endmodule

// File: rtl/add_imp_frame_ctrl.sv
// Collects a frame of nibbles into the operand bank, lets the ADD_IMP tree settle,
// then registers the total and hands it out over a valid/ready handshake.
module add_imp_frame_ctrl
  import add_imp_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  add_imp_frame_ctrl_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_OPS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(NUM_OPS);

  state_t           state;
  logic [OP_W-1:0]  bank [NUM_OPS];
  logic [3:0]       settle_cnt;
  logic [SUM_W-1:0] tree_sum;
  logic             accept;
  logic             bank_we;
  logic             bank_clr;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    bank_we  = 1'b0;
    bank_clr = 1'b0;
    case (state)
      IDLE, FILL: begin
        bank_clr = abort;
        bank_we  = accept && !abort;
      end
      SETTLE:  bank_clr = abort;
      HOLD:    bank_clr = bus.sum_ready;
      default: bank_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) bank[i] <= '0;
    end else if (bank_clr) begin
      for (int i = 0; i < NUM_OPS; i++) bank[i] <= '0;
    end else if (bank_we) begin
      bank[op_count[6:0]] <= bus.in_data;
    end
  end

  // Settle counter is loaded with SETTLE_CYC so the bank-stable cycle is not
  // counted as settle time; capture lands SETTLE_CYC+1 edges after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_count        <= '0;
      settle_cnt      <= '0;
      busy            <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.sum_valid   <= 1'b0;
      bus.sum_data    <= '0;
      bus.short_frame <= 1'b0;
    end else begin
      case (state)
        IDLE, FILL: begin
          if (abort) begin
            state        <= IDLE;
            op_count     <= '0;
            settle_cnt   <= '0;
            busy         <= 1'b0;
            bus.in_ready <= 1'b1;
          end else if (accept) begin
            op_count <= op_count + CNT_W'(1);
            busy     <= 1'b1;
            if (bus.in_last || op_count == LAST_IDX) begin
              state        <= SETTLE;
              settle_cnt   <= SETTLE_LOAD;
              bus.in_ready <= 1'b0;
            end else begin
              state <= FILL;
            end
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state        <= IDLE;
            op_count     <= '0;
            settle_cnt   <= '0;
            busy         <= 1'b0;
            bus.in_ready <= 1'b1;
          end else if (settle_cnt == '0) begin
            state           <= HOLD;
            bus.sum_valid   <= 1'b1;
            bus.sum_data    <= tree_sum;
            bus.short_frame <= (op_count < FULL_CNT);
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (bus.sum_ready) begin
            state           <= IDLE;
            op_count        <= '0;
            busy            <= 1'b0;
            bus.in_ready    <= 1'b1;
            bus.sum_valid   <= 1'b0;
            bus.short_frame <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          op_count      <= '0;
          settle_cnt    <= '0;
          busy          <= 1'b0;
          bus.in_ready  <= 1'b1;
          bus.sum_valid <= 1'b0;
        end
      endcase
    end
  end

  ADD_IMP u_tree (
    .a1  (bank[0]),   .a2  (bank[1]),   .a3  (bank[2]),   .a4  (bank[3]),   .a5  (bank[4]),   .a6  (bank[5]),   .a7  (bank[6]),   .a8  (bank[7]),
    .a9  (bank[8]),   .a10 (bank[9]),   .a11 (bank[10]),  .a12 (bank[11]),  .a13 (bank[12]),  .a14 (bank[13]),  .a15 (bank[14]),  .a16 (bank[15]),
    .a17 (bank[16]),  .a18 (bank[17]),  .a19 (bank[18]),  .a20 (bank[19]),  .a21 (bank[20]),  .a22 (bank[21]),  .a23 (bank[22]),  .a24 (bank[23]),
    .a25 (bank[24]),  .a26 (bank[25]),  .a27 (bank[26]),  .a28 (bank[27]),  .a29 (bank[28]),  .a30 (bank[29]),  .a31 (bank[30]),  .a32 (bank[31]),
    .a33 (bank[32]),  .a34 (bank[33]),  .a35 (bank[34]),  .a36 (bank[35]),  .a37 (bank[36]),  .a38 (bank[37]),  .a39 (bank[38]),  .a40 (bank[39]),
    .a41 (bank[40]),  .a42 (bank[41]),  .a43 (bank[42]),  .a44 (bank[43]),  .a45 (bank[44]),  .a46 (bank[45]),  .a47 (bank[46]),  .a48 (bank[47]),
    .a49 (bank[48]),  .a50 (bank[49]),  .a51 (bank[50]),  .a52 (bank[51]),  .a53 (bank[52]),  .a54 (bank[53]),  .a55 (bank[54]),  .a56 (bank[55]),
    .a57 (bank[56]),  .a58 (bank[57]),  .a59 (bank[58]),  .a60 (bank[59]),  .a61 (bank[60]),  .a62 (bank[61]),  .a63 (bank[62]),  .a64 (bank[63]),
    .a65 (bank[64]),  .a66 (bank[65]),  .a67 (bank[66]),  .a68 (bank[67]),  .a69 (bank[68]),  .a70 (bank[69]),  .a71 (bank[70]),  .a72 (bank[71]),
    .a73 (bank[72]),  .a74 (bank[73]),  .a75 (bank[74]),  .a76 (bank[75]),  .a77 (bank[76]),  .a78 (bank[77]),  .a79 (bank[78]),  .a80 (bank[79]),
    .a81 (bank[80]),  .a82 (bank[81]),  .a83 (bank[82]),  .a84 (bank[83]),  .a85 (bank[84]),  .a86 (bank[85]),  .a87 (bank[86]),  .a88 (bank[87]),
    .a89 (bank[88]),  .a90 (bank[89]),  .a91 (bank[90]),  .a92 (bank[91]),  .a93 (bank[92]),  .a94 (bank[93]),  .a95 (bank[94]),  .a96 (bank[95]),
    .a97 (bank[96]),  .a98 (bank[97]),  .a99 (bank[98]),  .a100(bank[99]),  .a101(bank[100]), .a102(bank[101]), .a103(bank[102]), .a104(bank[103]),
    .a105(bank[104]), .a106(bank[105]), .a107(bank[106]), .a108(bank[107]), .a109(bank[108]), .a110(bank[109]), .a111(bank[110]), .a112(bank[111]),
    .a113(bank[112]), .a114(bank[113]), .a115(bank[114]), .a116(bank[115]), .a117(bank[116]), .a118(bank[117]), .a119(bank[118]), .a120(bank[119]),
    .a121(bank[120]), .a122(bank[121]), .a123(bank[122]), .a124(bank[123]), .a125(bank[124]), .a126(bank[125]), .a127(bank[126]), .a128(bank[127]),
    .sum (tree_sum)
  );

  a_sum_bound: assert property (@(posedge clk) disable iff (!rst_n)
    bus.sum_valid |-> bus.sum_data <= max_sum());
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    op_count <= FULL_CNT);

endmodule

// File: tb/tb_add_imp_frame_ctrl.sv
// Directed-vector bench for add_imp_frame_ctrl with hand-computed frame sums.
module tb_add_imp_frame_ctrl;
  import add_imp_pkg::*;

  localparam int SETTLE_CYC = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             abort;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  add_imp_frame_ctrl_if bus ();

  add_imp_frame_ctrl #(.SETTLE_CYC(SETTLE_CYC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (abort),
    .bus      (bus.slave),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Offers one beat from a negedge and returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [3:0] data, input logic last, output int edge_no);
    bit took = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    for (int t = 0; t < 50 && !took; t++) begin
      took = bus.in_ready;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    edge_no = cyc;
    if (!took) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitSum(output int edge_no);
    edge_no = -1;
    for (int t = 0; t < 100; t++) begin
      if (bus.sum_valid) begin
        edge_no = cyc;
        break;
      end
      @(negedge clk);
    end
    if (edge_no < 0) checkOutput("sum_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int last_edge;
    int sum_edge;
    bit seen;
    logic [3:0] bp_vals [6];
    bp_vals = '{4'd7, 4'd3, 4'd9, 4'd2, 4'd8, 4'd4};

    rst_n         = 1'b0;
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.sum_ready = 1'b0;

    @(negedge clk);
    checkOutput("rst_in_ready", int'(bus.in_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_sum_valid", int'(bus.sum_valid), 0);
    checkOutput("rst_sum_data", int'(bus.sum_data), 0);
    checkOutput("rst_short", int'(bus.short_frame), 0);
    checkOutput("rst_op_count", int'(op_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_in_ready_hold", int'(bus.in_ready), 0);
    @(negedge clk);
    checkOutput("rst_in_ready_up", int'(bus.in_ready), 1);

    // Full frame of 0xF
    bus.sum_ready = 1'b1;
    for (int i = 0; i < 128; i++) applyStimulus(4'hF, i == 127, last_edge);
    checkOutput("full_in_ready_settle", int'(bus.in_ready), 0);
    checkOutput("full_busy", int'(busy), 1);
    waitSum(sum_edge);
    checkOutput("full_latency", sum_edge - last_edge, SETTLE_CYC + 1);
    checkOutput("full_sum", int'(bus.sum_data), 1920);
    checkOutput("full_short", int'(bus.short_frame), 0);
    @(negedge clk);
    checkOutput("full_drained", int'(bus.sum_valid), 0);
    checkOutput("full_op_count_clr", int'(op_count), 0);
    checkOutput("full_in_ready_idle", int'(bus.in_ready), 1);

    // Short frame 1,2,3 then a full frame of ones to expose stale slots
    applyStimulus(4'd1, 1'b0, last_edge);
    applyStimulus(4'd2, 1'b0, last_edge);
    applyStimulus(4'd3, 1'b1, last_edge);
    checkOutput("short_op_count", int'(op_count), 3);
    waitSum(sum_edge);
    checkOutput("short_latency", sum_edge - last_edge, SETTLE_CYC + 1);
    checkOutput("short_sum", int'(bus.sum_data), 6);
    checkOutput("short_flag", int'(bus.short_frame), 1);
    @(negedge clk);
    for (int i = 0; i < 128; i++) applyStimulus(4'd1, i == 127, last_edge);
    waitSum(sum_edge);
    checkOutput("ones_sum", int'(bus.sum_data), 128);
    checkOutput("ones_short", int'(bus.short_frame), 0);
    @(negedge clk);

    // 128 beats, in_last never set: count alone closes the frame
    for (int i = 0; i < 128; i++) applyStimulus(4'(i), 1'b0, last_edge);
    checkOutput("nolast_in_ready", int'(bus.in_ready), 0);
    checkOutput("nolast_op_count", int'(op_count), 128);
    waitSum(sum_edge);
    checkOutput("nolast_latency", sum_edge - last_edge, SETTLE_CYC + 1);
    checkOutput("nolast_sum", int'(bus.sum_data), 960);
    checkOutput("nolast_short", int'(bus.short_frame), 0);
    @(negedge clk);

    // Gapped input and consumer backpressure
    bus.sum_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(bp_vals[i], i == 5, last_edge);
      if (i != 5) @(negedge clk);
    end
    waitSum(sum_edge);
    checkOutput("bp_sum", int'(bus.sum_data), 33);
    checkOutput("bp_short", int'(bus.short_frame), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    for (int k = 0; k < 7; k++) begin
      checkOutput("bp_hold_valid", int'(bus.sum_valid), 1);
      checkOutput("bp_hold_data", int'(bus.sum_data), 33);
      checkOutput("bp_hold_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
    end
    checkOutput("bp_hold_op_count", int'(op_count), 6);
    bus.in_valid  = 1'b0;
    bus.sum_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_drained", int'(bus.sum_valid), 0);
    checkOutput("bp_idle", int'(busy), 0);
    @(negedge clk);
    checkOutput("bp_single_hs", int'(bus.sum_valid), 0);
    checkOutput("bp_op_count_clr", int'(op_count), 0);

    // Abort in FILL together with a beat
    for (int i = 0; i < 50; i++) applyStimulus(4'd1, 1'b0, last_edge);
    checkOutput("abort_pre_count", int'(op_count), 50);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd5;
    abort        = 1'b1;
    @(negedge clk);
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("abort_op_count", int'(op_count), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_in_ready", int'(bus.in_ready), 1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen |= bus.sum_valid;
      @(negedge clk);
    end
    checkOutput("abort_no_sum", int'(seen), 0);
    applyStimulus(4'd5, 1'b0, last_edge);
    applyStimulus(4'd5, 1'b1, last_edge);
    waitSum(sum_edge);
    checkOutput("abort_next_sum", int'(bus.sum_data), 10);
    @(negedge clk);

    // Abort while HOLD is ignored
    bus.sum_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(4'd4, i == 2, last_edge);
    waitSum(sum_edge);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("hold_abort_valid", int'(bus.sum_valid), 1);
    checkOutput("hold_abort_data", int'(bus.sum_data), 12);
    checkOutput("hold_abort_busy", int'(busy), 1);
    bus.sum_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_abort_drained", int'(bus.sum_valid), 0);

    // Asynchronous reset while in SETTLE
    applyStimulus(4'd2, 1'b0, last_edge);
    applyStimulus(4'd2, 1'b1, last_edge);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_in_ready", int'(bus.in_ready), 0);
    checkOutput("async_rst_op_count", int'(op_count), 0);
    checkOutput("async_rst_sum_valid", int'(bus.sum_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      seen |= bus.sum_valid;
      @(negedge clk);
    end
    checkOutput("async_rst_no_sum", int'(seen), 0);
    applyStimulus(4'd9, 1'b1, last_edge);
    waitSum(sum_edge);
    checkOutput("post_rst_sum", int'(bus.sum_data), 9);
    checkOutput("post_rst_short", int'(bus.short_frame), 1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
